// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: RAW scoreboard stalls,
// EX-stage redirects with wrong-path flushes, and external whole-pipeline freeze.
module pipe_ctrl #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_req,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  input  logic             rd_wen,
  input  logic             jump_en,
  input  logic [31:0]      jump_addr,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             jump_o,
  output logic [31:0]      jump_addr_o,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  // fcnt counts the flush cycles still owed after the current one.
  localparam logic [1:0] FcntInit = 2'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  state_e           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [DEPTH-1:0] sb_v_q, sb_v_d;
  logic [4:0]       sb_rd_q [DEPTH];
  logic [4:0]       sb_rd_d [DEPTH];

  logic       raw;
  logic       shift;
  logic       in_v;
  logic [4:0] in_rd;

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sb_v_q[i] && (sb_rd_q[i] != 5'd0)) begin
        if (((rs1_addr != 5'd0) && (sb_rd_q[i] == rs1_addr)) ||
            ((rs2_addr != 5'd0) && (sb_rd_q[i] == rs2_addr))) begin
          raw = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StRun;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      sb_v_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        sb_rd_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      sb_v_q      <= sb_v_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        sb_rd_q[i] <= sb_rd_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;
    shift       = 1'b0;
    in_v        = 1'b0;
    in_rd       = 5'd0;
    if (hold_req) begin
      shift = 1'b0;
    end else if (jump_en) begin
      shift = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        fcnt_d  = FcntInit;
      end else begin
        state_d = StRun;
      end
    end else if (state_q == StFlush) begin
      shift = 1'b1;
      if (fcnt_q == 2'd0) begin
        state_d = StRun;
      end else begin
        fcnt_d = fcnt_q - 2'd1;
      end
    end else if (raw) begin
      shift = 1'b1;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      shift = 1'b1;
      in_v  = rd_wen && (rd_addr != 5'd0);
      in_rd = rd_addr;
    end
  end

  // The oldest entry falls off the end: that is its regs write-back edge.
  always_comb begin
    sb_v_d  = sb_v_q;
    sb_rd_d = sb_rd_q;
    if (shift) begin
      sb_v_d[0]  = in_v;
      sb_rd_d[0] = in_rd;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sb_v_d[i]  = sb_v_q[i-1];
        sb_rd_d[i] = sb_rd_q[i-1];
      end
    end
  end

  always_comb begin
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = 32'd0;
    if (!rst) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hold_req) begin
      hold_pc    = 1'b1;
      hold_if_id = 1'b1;
      hold_id_ex = 1'b1;
    end else if (jump_en) begin
      jump_o      = 1'b1;
      jump_addr_o = jump_addr;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (state_q == StFlush) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (raw) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two configurations driven in lockstep, checked against an
// in-flight-instruction model built from the pipeline rules.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold_req, jump_en, rd_wen;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] jump_addr;

  logic        a_hold_pc, a_hold_if_id, a_hold_id_ex, a_flush_if_id, a_flush_id_ex, a_jump;
  logic [31:0] a_jaddr;
  logic [15:0] a_stall;
  logic        b_hold_pc, b_hold_if_id, b_hold_id_ex, b_flush_if_id, b_flush_id_ex, b_jump;
  logic [31:0] b_jaddr;
  logic [1:0]  b_stall;

  pipe_ctrl #(.DEPTH(2), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .hold_req(hold_req), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .jump_en(jump_en), .jump_addr(jump_addr),
    .hold_pc(a_hold_pc), .hold_if_id(a_hold_if_id), .hold_id_ex(a_hold_id_ex),
    .flush_if_id(a_flush_if_id), .flush_id_ex(a_flush_id_ex), .jump_o(a_jump),
    .jump_addr_o(a_jaddr), .stall_cnt(a_stall)
  );

  pipe_ctrl #(.DEPTH(3), .FLUSH_CYCLES(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .hold_req(hold_req), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .jump_en(jump_en), .jump_addr(jump_addr),
    .hold_pc(b_hold_pc), .hold_if_id(b_hold_if_id), .hold_id_ex(b_hold_id_ex),
    .flush_if_id(b_flush_if_id), .flush_id_ex(b_flush_id_ex), .jump_o(b_jump),
    .jump_addr_o(b_jaddr), .stall_cnt(b_stall)
  );

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  // Model: per config, destination of each in-flight instruction (0 = none), youngest first,
  // plus extra flush cycles still owed and the stall tally.
  int m_depth [2] = '{2, 3};
  int m_flush [2] = '{1, 3};
  int m_max   [2] = '{65535, 3};
  int m_sb    [2][4];
  int m_left  [2];
  int m_stall [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
  endtask

  function automatic bit m_raw(input int m);
    bit r = 1'b0;
    for (int i = 0; i < m_depth[m]; i++) begin
      if (m_sb[m][i] != 0 &&
          ((rs1_addr != 0 && m_sb[m][i] == int'(rs1_addr)) ||
           (rs2_addr != 0 && m_sb[m][i] == int'(rs2_addr)))) r = 1'b1;
    end
    return r;
  endfunction

  task automatic m_push(input int m, input int rd);
    for (int i = m_depth[m] - 1; i > 0; i--) m_sb[m][i] = m_sb[m][i-1];
    m_sb[m][0] = rd;
  endtask

  task automatic m_clear();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) m_sb[m][i] = 0;
      m_left[m]  = 0;
      m_stall[m] = 0;
    end
  endtask

  task automatic compare_all();
    logic [5:0]  ctrl;
    logic [31:0] addr;
    logic [5:0]  obs_ctrl;
    for (int m = 0; m < 2; m++) begin
      addr = 32'd0;
      // {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_o}
      if (!rst)                  ctrl = 6'b000110;
      else if (hold_req)         ctrl = 6'b111000;
      else if (jump_en) begin    ctrl = 6'b000111; addr = jump_addr; end
      else if (m_left[m] > 0)    ctrl = 6'b000110;
      else if (m_raw(m))         ctrl = 6'b110010;
      else                       ctrl = 6'b000000;
      if (m == 0) begin
        obs_ctrl = {a_hold_pc, a_hold_if_id, a_hold_id_ex, a_flush_if_id, a_flush_id_ex, a_jump};
        check("a_ctrl", 32'(obs_ctrl), 32'(ctrl));
        check("a_jump_addr", a_jaddr, addr);
        check("a_stall_cnt", 32'(a_stall), 32'(m_stall[0]));
      end else begin
        obs_ctrl = {b_hold_pc, b_hold_if_id, b_hold_id_ex, b_flush_if_id, b_flush_id_ex, b_jump};
        check("b_ctrl", 32'(obs_ctrl), 32'(ctrl));
        check("b_jump_addr", b_jaddr, addr);
        check("b_stall_cnt", 32'(b_stall), 32'(m_stall[1]));
      end
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      m_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (hold_req) begin
        // frozen
      end else if (jump_en) begin
        m_push(m, 0);
        m_left[m] = m_flush[m] - 1;
      end else if (m_left[m] > 0) begin
        m_push(m, 0);
        m_left[m]--;
      end else if (m_raw(m)) begin
        m_push(m, 0);
        if (m_stall[m] < m_max[m]) m_stall[m]++;
      end else begin
        m_push(m, rd_wen ? int'(rd_addr) : 0);
      end
    end
  endtask

  task automatic step(input logic h, input logic j, input logic [31:0] ja,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic w);
    hold_req  = h;
    jump_en   = j;
    jump_addr = ja;
    rs1_addr  = r1;
    rs2_addr  = r2;
    rd_addr   = rd;
    rd_wen    = w;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    step_init();
    // reset with a pending write: nothing may be tracked afterwards
    step(0, 0, 0, 0, 0, 5, 1);
    step(0, 0, 0, 0, 0, 5, 1);
    rst = 1'b1;
    step(0, 0, 0, 5, 0, 0, 0);
    check("post_reset_hold_pc", 32'(a_hold_pc), 32'd0);
    // RAW on rs1
    step(0, 0, 0, 0, 0, 5, 1);
    repeat (3) step(0, 0, 0, 5, 0, 0, 0);
    check("raw_rs1_cnt_a", 32'(a_stall), 32'd2);
    step(0, 0, 0, 0, 0, 0, 0);
    // RAW on rs2
    step(0, 0, 0, 0, 0, 6, 1);
    repeat (3) step(0, 0, 0, 0, 6, 0, 0);
    check("raw_rs2_cnt_a", 32'(a_stall), 32'd4);
    step(0, 0, 0, 0, 0, 0, 0);
    // x0 producer never stalls
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("x0_no_stall", 32'(a_hold_pc), 32'd0);
    // redirect and flush lengths
    step(0, 1, 32'h0000_0040, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    // hold beats jump and raw, then jump is re-presented
    step(0, 0, 0, 0, 0, 7, 1);
    step(1, 1, 32'h0000_0100, 7, 0, 0, 0);
    step(1, 1, 32'h0000_0100, 7, 0, 0, 0);
    check("hold_keeps_cnt_a", 32'(a_stall), 32'd4);
    step(0, 1, 32'h0000_0100, 7, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    // jump during raw: no stall counted
    step(0, 0, 0, 0, 0, 8, 1);
    step(0, 1, 32'h0000_0200, 8, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    // long stall: 2-bit counter saturates
    step(0, 0, 0, 0, 0, 9, 1);
    repeat (4) step(0, 0, 0, 9, 0, 0, 0);
    check("sat_cnt_b", 32'(b_stall), 32'd3);
    // jump during flush restarts the sequence
    step(0, 1, 32'h0000_0300, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0400, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // One unchecked reset edge so DUT registers are defined before the first comparison.
  task automatic step_init();
    hold_req  = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 32'd0;
    rs1_addr  = 5'd0;
    rs2_addr  = 5'd0;
    rd_addr   = 5'd0;
    rd_wen    = 1'b0;
    @(posedge clk);
    m_clear();
    #1;
  endtask

endmodule
